instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 155 +++++++++++++++
 tb/tb_instr_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: turns op/register/immediate requests into 32-bit words
// through a single registered output slot. Define PSEUDO_LI_EN to enable li.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [5:0]  out_opcode,
    output logic        err,
    output logic [15:0] word_count
);

    typedef enum logic {IDLE = 1'b0, EMIT_LO = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        err_q, err_d;
    logic [15:0] word_count_q, word_count_d;

    logic [31:0] enc_word;
    logic        illegal;
    logic        slot_free;
    logic        accept;
    logic        out_xfer;

`ifdef PSEUDO_LI_EN
    logic        is_li;
    logic [4:0]  li_rt_q, li_rt_d;
    logic [15:0] li_lo_q, li_lo_d;
`else
    logic [5:0]  unused_imm_hi;
    assign unused_imm_hi = in_imm[31:26];
`endif

    assign slot_free = !out_valid_q || out_ready;
    // rst_n gates in_ready so nothing looks acceptable while reset is held
    assign in_ready  = rst_n && (state_q == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;

    always_comb begin
        enc_word = 32'h0;
        illegal  = 1'b0;
`ifdef PSEUDO_LI_EN
        is_li    = 1'b0;
`endif
        case (in_op)
            4'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
            4'd1:  enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            4'd2:  enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            4'd3:  enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            4'd4:  enc_word = {6'b000101, in_rs, in_rt, in_imm[15:0]};
            4'd5:  enc_word = {6'b000010, in_imm[25:0]};
            4'd6:  enc_word = {6'b000011, in_imm[25:0]};
            4'd7:  enc_word = {6'b001000, in_rs, 21'b0};
            4'd8:  enc_word = {6'b001101, in_rs, in_rt, in_imm[15:0]};
            4'd9:  enc_word = {6'b001111, 5'b00000, in_rt, in_imm[15:0]};
`ifdef PSEUDO_LI_EN
            4'd10: begin
                enc_word = {6'b001111, 5'b00000, in_rt, in_imm[31:16]};
                is_li    = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        err_d        = 1'b0;
        word_count_d = word_count_q + {15'd0, out_xfer};
`ifdef PSEUDO_LI_EN
        li_rt_d      = li_rt_q;
        li_lo_d      = li_lo_q;
`endif
        if (out_xfer) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_instr_d = enc_word;
`ifdef PSEUDO_LI_EN
                        if (is_li) begin
                            state_d = EMIT_LO;
                            li_rt_d = in_rt;
                            li_lo_d = in_imm[15:0];
                        end
`endif
                    end
                end
            end
            EMIT_LO: begin
`ifdef PSEUDO_LI_EN
                // The lower half follows as soon as the slot can take it
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_instr_d = {6'b001101, li_rt_q, li_rt_q, li_lo_q};
                    state_d     = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0;
            err_q        <= 1'b0;
            word_count_q <= 16'h0;
`ifdef PSEUDO_LI_EN
            li_rt_q      <= 5'd0;
            li_lo_q      <= 16'h0;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
`ifdef PSEUDO_LI_EN
            li_rt_q      <= li_rt_d;
            li_lo_q      <= li_lo_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_opcode = out_instr_q[31:26];
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder; exercises li only when PSEUDO_LI_EN is defined.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [5:0]  in_funct;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_opcode;
    logic        err;
    logic [15:0] word_count;

    int errors = 0;
    int checks = 0;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_opcode(out_opcode),
        .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] funct, input logic [31:0] imm);
        in_valid = 1'b1;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = funct; in_imm = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_funct = 6'd0; in_imm = 32'd0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL reset_word_count got=%h exp=0", word_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        #2 rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_rtype();
        out_ready = 1'b1;
        drive(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 32'h0);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rtype_valid got=%b exp=1", out_valid); end
        checks++; if (out_instr !== 32'h00221820) begin errors++; $display("FAIL rtype_instr got=%h exp=00221820", out_instr); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL rtype_wc_before got=%0d exp=0", word_count); end
        step();
        checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL rtype_wc got=%0d exp=1", word_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rtype_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(4'd8, 5'd0, 5'd8, 5'd0, 6'd0, 32'h1234);
        step();
        checks++; if (out_instr !== 32'h34081234) begin errors++; $display("FAIL ori_instr got=%h exp=34081234", out_instr); end
        checks++; if (out_opcode !== 6'b001101) begin errors++; $display("FAIL ori_opcode got=%b exp=001101", out_opcode); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        drive(4'd5, 5'd0, 5'd0, 5'd0, 6'd0, 32'hFC00_0100);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got=%b exp=1", out_valid); end
        checks++; if (out_instr !== 32'h08000100) begin errors++; $display("FAIL j_instr got=%h exp=08000100", out_instr); end
        checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL b2b_wc_mid got=%0d exp=2", word_count); end
        step();
        checks++; if (word_count !== 16'd3) begin errors++; $display("FAIL b2b_wc got=%0d exp=3", word_count); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        drive(4'd1, 5'd29, 5'd4, 5'd0, 6'd0, 32'h0000FFFC);
        step();
        drive(4'd3, 5'd1, 5'd1, 5'd0, 6'd0, 32'h0000_0004);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_instr !== 32'h8FA4FFFC) begin errors++; $display("FAIL hold_instr[%0d] got=%h exp=8FA4FFFC", i, out_instr); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got=%b exp=0", out_valid); end
        checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL hold_wc got=%0d exp=4", word_count); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(4'd13, 5'd1, 5'd2, 5'd3, 6'd0, 32'h0);
        step();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b exp=1", err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got=%b exp=0", err); end
        checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL illegal_wc got=%0d exp=4", word_count); end
    endtask

    task automatic test_li();
`ifdef PSEUDO_LI_EN
        out_ready = 1'b0;
        drive(4'd10, 5'd0, 5'd9, 5'd0, 6'd0, 32'hDEADBEEF);
        step();
        in_valid = 1'b0;
        checks++; if (out_instr !== 32'h3C09DEAD) begin errors++; $display("FAIL li_hi got=%h exp=3C09DEAD", out_instr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL li_between_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL li_emit_ready got=%b exp=0", in_ready); end
        step();
        checks++; if (out_instr !== 32'h3529BEEF) begin errors++; $display("FAIL li_lo got=%h exp=3529BEEF", out_instr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL li_lo_valid got=%b exp=1", out_valid); end
        step();
        checks++; if (word_count !== 16'd6) begin errors++; $display("FAIL li_wc got=%0d exp=6", word_count); end
`else
        out_ready = 1'b1;
        drive(4'd10, 5'd0, 5'd9, 5'd0, 6'd0, 32'hDEADBEEF);
        step();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL li_off_err got=%b exp=1", err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL li_off_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL li_off_wc got=%0d exp=4", word_count); end
`endif
    endtask

    task automatic test_li_reset();
`ifdef PSEUDO_LI_EN
        out_ready = 1'b0;
        drive(4'd10, 5'd0, 5'd9, 5'd0, 6'd0, 32'hDEADBEEF);
        step();
        in_valid = 1'b0;
        checks++; if (out_instr !== 32'h3C09DEAD) begin errors++; $display("FAIL lirst_hi got=%h exp=3C09DEAD", out_instr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lirst_valid got=%b exp=0", out_valid); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL lirst_wc got=%0d exp=0", word_count); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lirst_no_ori[%0d] got=%b exp=0", i, out_valid); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lirst_idle_ready got=%b exp=1", in_ready); end
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_hold();
        test_illegal();
        test_li();
        test_li_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
